// File: rtl/fpu_req_arb_if.sv
// Core-side request/response and fpu_top-side signals of the FPU request arbiter.
// The arbiter uses the slave view; requesters and the FPU together form the master side.
interface fpu_req_arb_if #(
    parameter int NREQ = 4
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [4*NREQ-1:0]  req_cmd;
    logic [64*NREQ-1:0] req_din1;
    logic [64*NREQ-1:0] req_din2;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [63:0]        rsp_result;
    logic               rsp_err;
    logic [3:0]         fpu_cmd;
    logic [63:0]        fpu_din1;
    logic [63:0]        fpu_din2;
    logic               fpu_dval;
    logic [63:0]        fpu_result;
    logic               fpu_rdy;
    logic               busy;
    logic [GW-1:0]      gnt_id;

    modport slave (
        input  req_valid, req_cmd, req_din1, req_din2, fpu_result, fpu_rdy,
        output req_ready, rsp_valid, rsp_result, rsp_err,
               fpu_cmd, fpu_din1, fpu_din2, fpu_dval, busy, gnt_id
    );

    modport master (
        output req_valid, req_cmd, req_din1, req_din2, fpu_result, fpu_rdy,
        input  req_ready, rsp_valid, rsp_result, rsp_err,
               fpu_cmd, fpu_din1, fpu_din2, fpu_dval, busy, gnt_id
    );
endinterface

// File: rtl/fpu_req_arb.sv
// Round-robin arbiter sharing one fpu_top among NREQ requesters, with a single op in
// flight, an illegal-command shortcut and a timeout when the FPU never signals rdy.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no op in flight; arbitrate and latch winner's cmd/operands
// ISSUE  | accept pulse to winner; dval to FPU if cmd legal, else error
// SETTLE | one dead cycle so a stale rdy from the previous op is ignored
// WAIT   | wait for fpu_rdy or timeout
// RESP   | one-cycle response pulse to the granted requester
module fpu_req_arb #(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst,
    fpu_req_arb_if.slave arb_if
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TMO_CYC);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [63:0]     din1_q, din1_d;
    logic [63:0]     din2_q, din2_d;
    logic [63:0]     result_q, result_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic            busy_q;

    logic            found;
    logic [GW-1:0]   win;
    logic [NREQ-1:0] gnt_oh;
    logic            cmd_legal;

    function automatic logic is_legal(input logic [3:0] c);
        case (c)
            4'b0001, 4'b0010, 4'b0011,
            4'b0101, 4'b0110, 4'b0111: is_legal = 1'b1;
            default:                   is_legal = 1'b0;
        endcase
    endfunction

    assign gnt_oh    = NREQ'(1) << gnt_q;
    assign cmd_legal = is_legal(cmd_q);

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        int j;
        found = 1'b0;
        win   = last_q;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last_q) + k) % NREQ;
            if (!found && arb_if.req_valid[GW'(j)]) begin
                found = 1'b1;
                win   = GW'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        cmd_d       = cmd_q;
        din1_d      = din1_q;
        din2_d      = din2_q;
        result_d    = result_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = win;
                    cmd_d   = arb_if.req_cmd[4*win +: 4];
                    din1_d  = arb_if.req_din1[64*win +: 64];
                    din2_d  = arb_if.req_din2[64*win +: 64];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                last_d = gnt_q;
                cnt_d  = '0;
                if (cmd_legal) begin
                    state_d = S_SETTLE;
                end else begin
                    result_d    = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = gnt_oh;
                    state_d     = S_RESP;
                end
            end
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (arb_if.fpu_rdy) begin
                    result_d    = arb_if.fpu_result;
                    err_d       = 1'b0;
                    rsp_valid_d = gnt_oh;
                    state_d     = S_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    result_d    = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = gnt_oh;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= GW'(NREQ - 1);
            gnt_q       <= '0;
            cmd_q       <= '0;
            din1_q      <= '0;
            din2_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            cmd_q       <= cmd_d;
            din1_q      <= din1_d;
            din2_q      <= din2_d;
            result_q    <= result_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Only the accept and start pulses are decoded; both come from flops alone.
    assign arb_if.req_ready  = (state_q == S_ISSUE) ? gnt_oh : '0;
    assign arb_if.fpu_dval   = (state_q == S_ISSUE) && cmd_legal;
    assign arb_if.rsp_valid  = rsp_valid_q;
    assign arb_if.rsp_result = result_q;
    assign arb_if.rsp_err    = err_q;
    assign arb_if.fpu_cmd    = cmd_q;
    assign arb_if.fpu_din1   = din1_q;
    assign arb_if.fpu_din2   = din2_q;
    assign arb_if.busy       = busy_q;
    assign arb_if.gnt_id     = gnt_q;
endmodule

// File: tb/tb_fpu_req_arb.sv
// Scoreboard bench for fpu_req_arb with a behavioural FPU (real-valued SP/DP ops,
// programmable latency, hang and stale-rdy modes).
module tb_fpu_req_arb;
    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_req_arb_if #(.NREQ(NREQ)) bus ();
    fpu_req_arb #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (.clk(clk), .rst(rst), .arb_if(bus));

    typedef struct {
        int          id;
        logic [63:0] res;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_tot = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rdy_cyc = 0;
    int          rsp_cyc = 0;
    int          dval_cnt = 0;
    int          last_rdy_id = -1;
    bit          in_op = 0;
    logic [3:0]  cmd_ref = '0;
    int          fpu_lat = 1;
    bit          fpu_hang = 0;
    bit          stale_mode = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sp2dp(input logic [31:0] s);
        logic [10:0] e;
        e = {3'b000, s[30:23]} + 11'd896;
        return {s[31], e, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] dp2sp(input logic [63:0] d);
        logic [10:0] e;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [63:0] fpu_ref(input logic [3:0] c, input logic [63:0] a,
                                            input logic [63:0] b);
        real x, y, r;
        x = 0.0;
        y = 0.0;
        r = 0.0;
        case (c)
            4'b0001, 4'b0010, 4'b0011: begin
                x = $bitstoreal(sp2dp(a[31:0]));
                y = $bitstoreal(sp2dp(b[31:0]));
                r = (c == 4'b0001) ? x + y : (c == 4'b0010) ? x * y : x / y;
                return {32'd0, dp2sp($realtobits(r))};
            end
            4'b0101, 4'b0110, 4'b0111: begin
                x = $bitstoreal(a);
                y = $bitstoreal(b);
                r = (c == 4'b0101) ? x + y : (c == 4'b0110) ? x * y : x / y;
                return $realtobits(r);
            end
            default: return 64'd0;
        endcase
    endfunction

    // Behavioural FPU: rdy rises fpu_lat cycles after dval and stays high until the next dval.
    int          m_cnt;
    bit          m_drop;
    logic [3:0]  m_cmd;
    logic [63:0] m_a, m_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fpu_rdy    <= 1'b0;
            bus.fpu_result <= '0;
            m_cnt          <= 0;
            m_drop         <= 1'b0;
        end else if (bus.fpu_dval) begin
            if (!stale_mode) bus.fpu_rdy <= 1'b0;
            m_drop <= stale_mode;
            m_cnt  <= fpu_lat;
            m_cmd  <= bus.fpu_cmd;
            m_a    <= bus.fpu_din1;
            m_b    <= bus.fpu_din2;
        end else begin
            if (m_drop) begin
                bus.fpu_rdy <= 1'b0;
                m_drop      <= 1'b0;
            end
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && !fpu_hang) begin
                    bus.fpu_rdy    <= 1'b1;
                    bus.fpu_result <= fpu_ref(m_cmd, m_a, m_b);
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            in_op = 0;
        end else begin
            check_val("ready_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
            check_val("rsp_onehot", 64'($onehot0(bus.rsp_valid)), 64'd1);
            if (bus.fpu_dval) dval_cnt++;
            if (bus.req_ready != '0) begin
                rdy_cyc     = cyc;
                last_rdy_id = int'(bus.gnt_id);
                cmd_ref     = bus.fpu_cmd;
                in_op       = 1;
            end else if (in_op) begin
                check_val("cmd_stable", 64'(bus.fpu_cmd), 64'(cmd_ref));
            end
            if (bus.rsp_valid != '0) begin
                rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    check_val("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("rsp_id", 64'(bus.rsp_valid), 64'd1 << e.id);
                    check_val("rsp_result", bus.rsp_result, e.res);
                    check_val("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    check_val("ready_before_rsp", 64'(last_rdy_id), 64'(e.id));
                end
                in_op = 0;
            end
        end
    end

    task automatic drive(input int id, input logic [3:0] c, input logic [63:0] a,
                         input logic [63:0] b);
        bus.req_valid[id]        = 1'b1;
        bus.req_cmd[4*id +: 4]   = c;
        bus.req_din1[64*id +: 64] = a;
        bus.req_din2[64*id +: 64] = b;
    endtask

    task automatic expect_rsp(input int id, input logic [63:0] res, input logic err);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.err = err;
        sb.push_back(e);
    endtask

    // Requesters drop valid once accepted.
    task automatic serve(input int budget);
        for (int i = 0; i < budget && bus.req_valid != '0; i++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < NREQ; k++)
                if (bus.req_ready[k]) bus.req_valid[k] = 1'b0;
        end
        check_val("accept_bound", 64'(bus.req_valid), 64'd0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !bus.busy) break;
            @(negedge clk);
            #1;
        end
        check_val("drain_bound", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
        check_val({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check_val({tag, "_rsp_result"}, bus.rsp_result, 64'd0);
        check_val({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        check_val({tag, "_fpu_cmd"}, 64'(bus.fpu_cmd), 64'd0);
        check_val({tag, "_fpu_din1"}, bus.fpu_din1, 64'd0);
        check_val({tag, "_fpu_din2"}, bus.fpu_din2, 64'd0);
        check_val({tag, "_fpu_dval"}, 64'(bus.fpu_dval), 64'd0);
        check_val({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_val({tag, "_gnt_id"}, 64'(bus.gnt_id), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          dv0;
        int          grants;
        logic [63:0] a, b;

        bus.req_valid = '0;
        bus.req_cmd   = '0;
        bus.req_din1  = '0;
        bus.req_din2  = '0;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        check_zero("after_reset");

        // Round robin: all four hold DP adds; grants must go 0,1,2,3,0.
        fpu_lat = 2;
        b = $realtobits(0.25);
        for (int i = 0; i < NREQ; i++) drive(i, 4'b0101, $realtobits(1.0 + i), b);
        for (int i = 0; i < 5; i++)
            expect_rsp(i % NREQ, fpu_ref(4'b0101, $realtobits(1.0 + (i % NREQ)), b), 1'b0);
        grants = 0;
        for (int i = 0; i < 200 && grants < 5; i++) begin
            @(negedge clk);
            #1;
            if (bus.req_ready != '0) grants++;
            if (grants == 5) bus.req_valid = '0;
        end
        check_val("rr_grants", 64'(grants), 64'd5);
        bus.req_valid = '0;
        drain(60);

        // Single SP add on req0 with the shortest FPU latency.
        fpu_lat = 1;
        dv0  = dval_cnt;
        base = cyc;
        drive(0, 4'b0001, 64'h3F80_0000, 64'h4000_0000);
        expect_rsp(0, 64'h0000_0000_4040_0000, 1'b0);
        serve(20);
        drain(50);
        check_val("sp_ready_cycle", 64'(rdy_cyc - base), 64'd1);
        check_val("sp_rsp_cycle", 64'(rsp_cyc - base), 64'd4);
        check_val("sp_dval_pulses", 64'(dval_cnt - dv0), 64'd1);

        // DP mul on req2, FPU latency 3.
        fpu_lat = 3;
        base = cyc;
        drive(2, 4'b0110, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
        expect_rsp(2, 64'h4018_0000_0000_0000, 1'b0);
        serve(20);
        drain(50);
        check_val("mul_gnt_id", 64'(bus.gnt_id), 64'd2);
        check_val("mul_rsp_cycle", 64'(rsp_cyc - base), 64'd6);

        // rdy left high from the previous op and held through SETTLE must be ignored.
        fpu_lat    = 2;
        stale_mode = 1;
        base = cyc;
        a = $realtobits(1.5);
        drive(3, 4'b0101, a, a);
        expect_rsp(3, 64'h4008_0000_0000_0000, 1'b0);
        serve(20);
        drain(50);
        stale_mode = 0;
        check_val("stale_rsp_cycle", 64'(rsp_cyc - base), 64'd5);

        // Illegal cmd on req1: no dval, error response in cycle 2.
        dv0  = dval_cnt;
        base = cyc;
        drive(1, 4'b0100, 64'h1234, 64'h5678);
        expect_rsp(1, 64'd0, 1'b1);
        serve(20);
        drain(50);
        check_val("ill_ready_cycle", 64'(rdy_cyc - base), 64'd1);
        check_val("ill_rsp_cycle", 64'(rsp_cyc - base), 64'd2);
        check_val("ill_dval_pulses", 64'(dval_cnt - dv0), 64'd0);

        // Timeout: FPU never answers.
        fpu_hang = 1;
        base = cyc;
        drive(3, 4'b0111, $realtobits(9.0), $realtobits(3.0));
        expect_rsp(3, 64'd0, 1'b1);
        serve(20);
        drain(50);
        check_val("tmo_rsp_cycle", 64'(rsp_cyc - base), 64'(TMO + 2));
        fpu_hang = 0;
        fpu_lat  = 1;
        a = $realtobits(2.5);
        b = $realtobits(4.0);
        drive(1, 4'b0101, a, b);
        expect_rsp(1, fpu_ref(4'b0101, a, b), 1'b0);
        serve(20);
        drain(50);

        // Reset during WAIT of a DP div.
        fpu_lat = 20;
        drive(0, 4'b0111, $realtobits(6.0), $realtobits(2.0));
        expect_rsp(0, 64'h4008_0000_0000_0000, 1'b0);
        serve(20);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check_val("pre_abort_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check_zero("abort");
        sb.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        fpu_lat = 2;
        a = $realtobits(0.5);
        b = $realtobits(8.0);
        drive(1, 4'b0101, b, b);
        drive(0, 4'b0101, a, a);
        expect_rsp(0, fpu_ref(4'b0101, a, a), 1'b0);
        expect_rsp(1, fpu_ref(4'b0101, b, b), 1'b0);
        serve(40);
        drain(60);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
